// File: rtl/unified_main_memory.sv
// unified_main_memory: dual-port word memory.
// Port A read-only, port B read/write with byte lanes.
module unified_main_memory #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address_a,
  output logic [31:0] read_data_a,
  input  logic [31:0] address_b,
  input  logic [31:0] write_data_b,
  input  logic        write_enable_b,
  input  logic [3:0]  byte_enable_b,
  output logic [31:0] read_data_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] memory [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] index_a;
  logic [ADDR_WIDTH-1:0] index_b;

  assign index_a = address_a[ADDR_WIDTH+1:2];
  assign index_b = address_b[ADDR_WIDTH+1:2];

  // Offset and alias bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_a[31:ADDR_WIDTH+2],
                              address_a[1:0],
                              address_b[31:ADDR_WIDTH+2],
                              address_b[1:0]};

  // Byte-lane writes; array is never cleared, writes gated by reset.
  always_ff @(posedge clk) begin
    if (rst_n && write_enable_b) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable_b[i]) begin
          memory[index_b][8*i +: 8] <= write_data_b[8*i +: 8];
        end
      end
    end
  end

  // Registered reads, read-first against same-edge writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_a <= '0;
      read_data_b <= '0;
    end else begin
      read_data_a <= memory[index_a];
      read_data_b <= memory[index_b];
    end
  end

endmodule

// File: tb/tb_unified_main_memory.sv
// tb_unified_main_memory: directed vector bench
// for the unified dual-port main memory.
module tb_unified_main_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] address_a;
  logic [31:0] read_data_a;
  logic [31:0] address_b;
  logic [31:0] write_data_b;
  logic        write_enable_b;
  logic [3:0]  byte_enable_b;
  logic [31:0] read_data_b;

  int checks;
  int errors;

  unified_main_memory #(.ADDR_WIDTH(14)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address_a      (address_a),
    .read_data_a    (read_data_a),
    .address_b      (address_b),
    .write_data_b   (write_data_b),
    .write_enable_b (write_enable_b),
    .byte_enable_b  (byte_enable_b),
    .read_data_b    (read_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_a;
    logic [31:0] exp_a;
    logic        chk_b;
    logic [31:0] exp_b;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [31:0] aa, input logic [31:0] ab,
    input logic we, input logic [3:0] be,
    input logic [31:0] wd,
    input logic ca, input logic [31:0] ea,
    input logic cb, input logic [31:0] eb);
    vec_t v;
    v.addr_a = aa; v.addr_b = ab;
    v.we = we; v.be = be; v.wdata = wd;
    v.chk_a = ca; v.exp_a = ea;
    v.chk_b = cb; v.exp_b = eb;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // aa, ab, we, be, wdata, chk_a, exp_a, chk_b, exp_b
    vecs[0]  = mk(32'h0, 32'h100, 1, 4'hF, 32'hDEADBEEF,
                  1, 32'h13, 0, 32'h0);
    vecs[1]  = mk(32'h100, 32'h100, 0, 4'h0, 32'h0,
                  1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[2]  = mk(32'h20, 32'h20, 1, 4'b0101, 32'hAABBCCDD,
                  1, 32'h11223344, 1, 32'h11223344);
    vecs[3]  = mk(32'h20, 32'h20, 1, 4'b0000, 32'hFFFFFFFF,
                  1, 32'h11BB33DD, 1, 32'h11BB33DD);
    vecs[4]  = mk(32'h20, 32'h20, 0, 4'h0, 32'h0,
                  1, 32'h11BB33DD, 1, 32'h11BB33DD);
    vecs[5]  = mk(32'h40, 32'h40, 1, 4'hF, 32'h12345678,
                  1, 32'h0, 1, 32'h0);
    vecs[6]  = mk(32'h40, 32'h40, 0, 4'h0, 32'h0,
                  1, 32'h12345678, 1, 32'h12345678);
    vecs[7]  = mk(32'h100, 32'h104, 1, 4'hF, 32'hCAFEF00D,
                  1, 32'hDEADBEEF, 0, 32'h0);
    vecs[8]  = mk(32'h105, 32'h107, 0, 4'h0, 32'h0,
                  1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    vecs[9]  = mk(32'h10104, 32'h80010104, 0, 4'h0, 32'h0,
                  1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    vecs[10] = mk(32'h104, 32'h104, 0, 4'hF, 32'h0,
                  1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    vecs[11] = mk(32'h104, 32'h104, 0, 4'h0, 32'h0,
                  1, 32'hCAFEF00D, 1, 32'hCAFEF00D);

    rst_n          = 1'b0;
    address_a      = '0;
    address_b      = '0;
    write_data_b   = '0;
    write_enable_b = 1'b0;
    byte_enable_b  = '0;

    dut.memory[0]  = 32'h00000013;
    dut.memory[8]  = 32'h11223344;
    dut.memory[16] = 32'h00000000;

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", read_data_a, 32'h0);
    check("reset_b", read_data_b, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      address_a      = vecs[i].addr_a;
      address_b      = vecs[i].addr_b;
      write_enable_b = vecs[i].we;
      byte_enable_b  = vecs[i].be;
      write_data_b   = vecs[i].wdata;
      @(posedge clk);
      #1;
      if (vecs[i].chk_a)
        check($sformatf("vec%0d_a", i), read_data_a, vecs[i].exp_a);
      if (vecs[i].chk_b)
        check($sformatf("vec%0d_b", i), read_data_b, vecs[i].exp_b);
    end

    // Async reset mid-cycle with a write pending.
    @(negedge clk);
    write_enable_b = 1'b1;
    byte_enable_b  = 4'hF;
    write_data_b   = 32'h0;
    address_b      = 32'h104;
    address_a      = 32'h104;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", read_data_a, 32'h0);
    check("async_rst_b", read_data_b, 32'h0);
    @(posedge clk);
    #1;
    check("held_rst_a", read_data_a, 32'h0);
    check("held_rst_b", read_data_b, 32'h0);

    @(negedge clk);
    write_enable_b = 1'b0;
    byte_enable_b  = 4'h0;
    rst_n = 1'b1;
    #1;
    check("post_rel_a", read_data_a, 32'h0);
    check("post_rel_b", read_data_b, 32'h0);
    @(posedge clk);
    #1;
    check("dropped_wr_a", read_data_a, 32'hCAFEF00D);
    check("dropped_wr_b", read_data_b, 32'hCAFEF00D);

    // Preloaded word still readable after reset.
    @(negedge clk);
    address_a = 32'h0;
    @(posedge clk);
    #1;
    check("preload_a", read_data_a, 32'h00000013);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
